// File: rtl/stall_unit_pkg.sv
// Shared encodings for the hazard controller: result classes, forwarding
// selects, the per-stage record layout and the Tnew derivations.
package stall_unit_pkg;

  localparam int unsigned RES_W  = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TUSE_W = 2;
  localparam int unsigned SEL_W  = 2;

  // Result classes
  localparam logic [RES_W-1:0] RES_NW    = 3'd0;
  localparam logic [RES_W-1:0] RES_ALU   = 3'd1;
  localparam logic [RES_W-1:0] RES_DM    = 3'd2;
  localparam logic [RES_W-1:0] RES_PC    = 3'd3;
  localparam logic [RES_W-1:0] RES_OTHER = 3'd4;

  // D-stage operand selects
  localparam logic [SEL_W-1:0] FWD_D_RF = 2'd0;
  localparam logic [SEL_W-1:0] FWD_D_E  = 2'd1;
  localparam logic [SEL_W-1:0] FWD_D_M  = 2'd2;
  localparam logic [SEL_W-1:0] FWD_D_W  = 2'd3;

  // E-stage ALU operand selects
  localparam logic [SEL_W-1:0] FWD_E_PIPE = 2'd0;
  localparam logic [SEL_W-1:0] FWD_E_M    = 2'd1;
  localparam logic [SEL_W-1:0] FWD_E_W    = 2'd2;

  // M-stage store-data select
  localparam logic FWD_M_PIPE = 1'b0;
  localparam logic FWD_M_W    = 1'b1;

  // Tuse value meaning "operand not read"
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [RES_W-1:0] res;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '{res: RES_NW, dst: '0, rs: '0, rt: '0};

  // Cycles until the result is available while the instruction sits in E.
  function automatic logic [TUSE_W-1:0] tnew_in_e(input logic [RES_W-1:0] res);
    case (res)
      RES_ALU:                    tnew_in_e = 2'd1;
      RES_DM:                     tnew_in_e = 2'd2;
      RES_PC, RES_OTHER, RES_NW:  tnew_in_e = 2'd0;
      default:                    tnew_in_e = 2'd0;
    endcase
  endfunction

  // Cycles until the result is available while the instruction sits in M.
  function automatic logic [TUSE_W-1:0] tnew_in_m(input logic [RES_W-1:0] res);
    tnew_in_m = (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/stall_unit_rec.sv
// stage_rec: one pipeline-stage record {res, dst, rs, rt} with async reset
// and a bubble-load input that overrides the data input.
//   clk, reset : clock / async active-high reset (loads a bubble)
//   bubble     : load {nw,0,0,0} instead of d on this edge
//   d, q       : next / current record
module stage_rec
  import stall_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= REC_BUBBLE;
    end else if (bubble) begin
      q <= REC_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/stall_unit.sv
// stall_unit: centralised hazard controller. Tracks in-flight writers in
// E/M/W and produces the pipeline stall plus all bypass-mux selects.
//   clk, reset           : clock / async active-high reset
//   tuse_rs_d, tuse_rt_d : cycles until D needs rs/rt (3 = unused)
//   res_d, dst_d         : result class / destination of the D instruction
//   rs_d, rt_d           : source registers in D
//   stall                : freeze PC and IF/ID, bubble ID/EX (combinational)
//   fwd_rs_d, fwd_rt_d   : D operand select 0 rf / 1 E / 2 M / 3 W
//   fwd_rs_e, fwd_rt_e   : E operand select 0 pipe / 1 M / 2 W
//   fwd_rt_m             : M store-data select 0 pipe / 1 W
module stall_unit
  import stall_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [TUSE_W-1:0] tuse_rs_d,
  input  logic [TUSE_W-1:0] tuse_rt_d,
  input  logic [RES_W-1:0]  res_d,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic [REG_W-1:0]  dst_d,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_d,
  output logic [SEL_W-1:0]  fwd_rt_d,
  output logic [SEL_W-1:0]  fwd_rs_e,
  output logic [SEL_W-1:0]  fwd_rt_e,
  output logic              fwd_rt_m
);

  stage_rec_t rec_d, rec_e, rec_m, rec_w;
  logic [TUSE_W-1:0] tnew_e, tnew_m;

  always_comb begin
    rec_d = '{res: res_d, dst: dst_d, rs: rs_d, rt: rt_d};
  end

  // E takes a bubble on stall; M and W always advance.
  stage_rec u_rec_e (.clk(clk), .reset(reset), .bubble(stall), .d(rec_d), .q(rec_e));
  stage_rec u_rec_m (.clk(clk), .reset(reset), .bubble(1'b0),  .d(rec_e), .q(rec_m));
  stage_rec u_rec_w (.clk(clk), .reset(reset), .bubble(1'b0),  .d(rec_m), .q(rec_w));

  always_comb begin
    tnew_e = tnew_in_e(rec_e.res);
    tnew_m = tnew_in_m(rec_m.res);
  end

  // A source stalls D if E or M will not have its value in time.
  function automatic logic hazard(input logic [REG_W-1:0]  src,
                                  input logic [TUSE_W-1:0] tuse,
                                  input logic [REG_W-1:0]  dst_e,
                                  input logic [TUSE_W-1:0] te,
                                  input logic [REG_W-1:0]  dst_m,
                                  input logic [TUSE_W-1:0] tm);
    hazard = (src != '0) && (tuse != TUSE_NONE) &&
             (((src == dst_e) && (te > tuse)) || ((src == dst_m) && (tm > tuse)));
  endfunction

  // Youngest matching stage wins; a not-yet-ready youngest match yields 0
  // rather than falling back to an older stage.
  function automatic logic [SEL_W-1:0] pick_d(input logic [REG_W-1:0] src,
                                              input stage_rec_t e, input logic [TUSE_W-1:0] te,
                                              input stage_rec_t m, input logic [TUSE_W-1:0] tm,
                                              input stage_rec_t w);
    pick_d = FWD_D_RF;
    if (src != '0) begin
      if (src == e.dst)      pick_d = (te == 2'd0) ? FWD_D_E : FWD_D_RF;
      else if (src == m.dst) pick_d = (tm == 2'd0) ? FWD_D_M : FWD_D_RF;
      else if (src == w.dst) pick_d = FWD_D_W;
    end
  endfunction

  function automatic logic [SEL_W-1:0] pick_e(input logic [REG_W-1:0] src,
                                              input stage_rec_t m, input logic [TUSE_W-1:0] tm,
                                              input stage_rec_t w);
    pick_e = FWD_E_PIPE;
    if (src != '0) begin
      if (src == m.dst)      pick_e = (tm == 2'd0) ? FWD_E_M : FWD_E_PIPE;
      else if (src == w.dst) pick_e = FWD_E_W;
    end
  endfunction

  // Stall
  always_comb begin
    stall = hazard(rs_d, tuse_rs_d, rec_e.dst, tnew_e, rec_m.dst, tnew_m) |
            hazard(rt_d, tuse_rt_d, rec_e.dst, tnew_e, rec_m.dst, tnew_m);
  end

  // Forwarding selects for D, E and M
  always_comb begin
    fwd_rs_d = pick_d(rs_d, rec_e, tnew_e, rec_m, tnew_m, rec_w);
    fwd_rt_d = pick_d(rt_d, rec_e, tnew_e, rec_m, tnew_m, rec_w);
    fwd_rs_e = pick_e(rec_e.rs, rec_m, tnew_m, rec_w);
    fwd_rt_e = pick_e(rec_e.rt, rec_m, tnew_m, rec_w);
    fwd_rt_m = ((rec_m.rt != '0) && (rec_m.rt == rec_w.dst)) ? FWD_M_W : FWD_M_PIPE;
  end

  // Record fields with no consumer in this block
  logic unused_rec_bits;
  assign unused_rec_bits = ^{rec_m.rs, rec_w.res, rec_w.rs, rec_w.rt};

endmodule

// File: tb/tb_stall_unit.sv
// Testbench for stall_unit: directed hazard sequences plus random traffic,
// checked against an in-bench pipeline model through a scoreboard queue.
module tb_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] tuse_rs_d, tuse_rt_d;
  logic [2:0] res_d;
  logic [4:0] rs_d, rt_d, dst_d;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m;

  stall_unit dut (
    .clk(clk), .reset(reset),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .res_d(res_d), .rs_d(rs_d), .rt_d(rt_d), .dst_d(dst_d),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res; int dst; int rs; int rt; int tuse_rs; int tuse_rt;
  } ins_t;

  typedef struct {
    int stall; int rs_d; int rt_d; int rs_e; int rt_e; int rt_m;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: in-flight instructions by age, 0 = E, 1 = M, 2 = W.
  int   p_res[3], p_dst[3], p_rs[3], p_rt[3];
  ins_t cur;
  int   last_stall;

  function automatic ins_t mk(int res, int dst, int rs, int rt, int tu_rs, int tu_rt);
    ins_t i;
    i.res = res; i.dst = dst; i.rs = rs; i.rt = rt; i.tuse_rs = tu_rs; i.tuse_rt = tu_rt;
    return i;
  endfunction

  // Stage offset (from E) at whose end the result exists: alu after E, dm after M.
  function automatic int ready_stage(int res);
    if (res == 1) return 1;
    if (res == 2) return 2;
    return 0;
  endfunction

  function automatic int tnew(int s);
    int t;
    t = ready_stage(p_res[s]) - s;
    return (t > 0) ? t : 0;
  endfunction

  // Select code counts stages from the first stage the consumer can see.
  function automatic int fwd_sel(int src, int first);
    for (int s = first; s < 3; s++)
      if (src != 0 && p_dst[s] == src) return (tnew(s) == 0) ? (s - first + 1) : 0;
    return 0;
  endfunction

  function automatic int needs_stall(int src, int tuse);
    if (src == 0 || tuse >= 3) return 0;
    for (int s = 0; s < 2; s++)
      if (p_dst[s] == src && tnew(s) > tuse) return 1;
    return 0;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 3; s++) begin
      p_res[s] = 0; p_dst[s] = 0; p_rs[s] = 0; p_rt[s] = 0;
    end
    last_stall = 0;
  endtask

  task automatic advance();
    if (reset) begin
      clear_model();
    end else begin
      for (int s = 2; s > 0; s--) begin
        p_res[s] = p_res[s-1]; p_dst[s] = p_dst[s-1];
        p_rs[s]  = p_rs[s-1];  p_rt[s]  = p_rt[s-1];
      end
      if (last_stall != 0) begin
        p_res[0] = 0; p_dst[0] = 0; p_rs[0] = 0; p_rt[0] = 0;
      end else begin
        p_res[0] = cur.res; p_dst[0] = cur.dst; p_rs[0] = cur.rs; p_rt[0] = cur.rt;
      end
    end
  endtask

  task automatic drive(input ins_t i);
    cur       = i;
    res_d     = 3'(i.res);
    dst_d     = 5'(i.dst);
    rs_d      = 5'(i.rs);
    rt_d      = 5'(i.rt);
    tuse_rs_d = 2'(i.tuse_rs);
    tuse_rt_d = 2'(i.tuse_rt);
  endtask

  task automatic expect_now();
    exp_t e;
    e.stall = (needs_stall(cur.rs, cur.tuse_rs) != 0 || needs_stall(cur.rt, cur.tuse_rt) != 0) ? 1 : 0;
    e.rs_d  = fwd_sel(cur.rs, 0);
    e.rt_d  = fwd_sel(cur.rt, 0);
    e.rs_e  = fwd_sel(p_rs[0], 1);
    e.rt_e  = fwd_sel(p_rt[0], 1);
    e.rt_m  = fwd_sel(p_rt[1], 2);
    last_stall = e.stall;
    sb.push_back(e);
  endtask

  // One cycle: update the model for the edge, then present the instruction.
  task automatic step(input ins_t i);
    @(posedge clk);
    advance();
    #1;
    drive(i);
    expect_now();
  endtask

  // Hold the instruction in D until the model says it is no longer stalled.
  task automatic issue(input ins_t i);
    step(i);
    for (int n = 0; n < 4 && last_stall != 0; n++) step(i);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare at the falling edge or on demand.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall",    int'(stall),    e.stall);
        chk("fwd_rs_d", int'(fwd_rs_d), e.rs_d);
        chk("fwd_rt_d", int'(fwd_rt_d), e.rt_d);
        chk("fwd_rs_e", int'(fwd_rs_e), e.rs_e);
        chk("fwd_rt_e", int'(fwd_rt_e), e.rt_e);
        chk("fwd_rt_m", int'(fwd_rt_m), e.rt_m);
      end
    end
  end

  initial begin
    ins_t nop, lw1, addu2, lw3, beq3, addu4, beq4, jal, jr31, lw0, addu5, lw6, sw6, r;
    nop   = mk(0, 0,  0, 0, 3, 3);
    lw1   = mk(2, 1,  0, 1, 1, 3);
    addu2 = mk(1, 2,  1, 1, 1, 1);
    lw3   = mk(2, 3,  0, 3, 1, 3);
    beq3  = mk(0, 0,  3, 0, 0, 0);
    addu4 = mk(1, 4,  0, 0, 1, 1);
    beq4  = mk(0, 0,  4, 4, 0, 0);
    jal   = mk(3, 31, 0, 0, 3, 3);
    jr31  = mk(0, 0, 31, 0, 0, 3);
    lw0   = mk(2, 0,  0, 0, 1, 3);
    addu5 = mk(1, 5,  0, 0, 1, 1);
    lw6   = mk(2, 6,  0, 6, 1, 3);
    sw6   = mk(0, 0,  0, 6, 1, 2);

    // Reset state, with hazard-looking inputs on D
    reset = 1'b1;
    clear_model();
    drive(addu2);
    #3;
    expect_now();
    -> sample_ev;
    step(lw1);
    step(addu2);
    #2 reset = 1'b0;

    // Load-use, load-branch, alu-branch, jal forward, zero reg, store data
    issue(nop); issue(lw1); issue(addu2); repeat (3) issue(nop);
    issue(lw3); issue(beq3); repeat (3) issue(nop);
    issue(addu4); issue(beq4); repeat (3) issue(nop);
    issue(jal); issue(jr31); repeat (3) issue(nop);
    issue(lw0); issue(addu5); repeat (3) issue(nop);
    issue(lw6); issue(sw6); repeat (3) issue(nop);

    // Reset pulsed during the first load-branch stall cycle
    issue(lw3);
    step(beq3);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    clear_model();
    expect_now();
    -> sample_ev;
    #1;
    drive(nop);
    reset = 1'b0;
    repeat (3) issue(nop);

    // Random traffic over a small register set to provoke hazards
    for (int k = 0; k < 300; k++) begin
      r.res     = int'($urandom_range(0, 4));
      r.dst     = (r.res == 0) ? 0 : int'($urandom_range(0, 3));
      r.rs      = int'($urandom_range(0, 3));
      r.rt      = int'($urandom_range(0, 3));
      r.tuse_rs = int'($urandom_range(0, 3));
      r.tuse_rt = int'($urandom_range(0, 3));
      issue(r);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
